// File: rtl/conv_mac_pool_bank.sv
// conv_mac_pool_bank: multi-channel 3x3 conv MAC over a 4x4 patch with framed accumulation, bias, ReLU, descale and 2x2 max-pool
module conv_mac_pool_bank #(
  parameter int NUM_CH     = 8,
  parameter int DATA_W     = 8,
  parameter int WGT_W      = 8,
  parameter int ACC_W      = 32,
  parameter int BIAS_W     = 16,
  parameter int BIAS_SHIFT = 0,
  parameter int SHIFT      = 7,
  parameter int OUT_W      = 8
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        i_vld,
  input  logic                        i_first,
  input  logic                        i_last,
  input  logic [NUM_CH*16*DATA_W-1:0] i_din,
  input  logic [NUM_CH*9*WGT_W-1:0]   i_wgt,
  input  logic [BIAS_W-1:0]           i_bias,
  output logic                        o_vld,
  output logic [OUT_W-1:0]            o_px,
  output logic [4*OUT_W-1:0]          o_pos,
  output logic                        o_busy,
  output logic                        o_err
);
  localparam int PW = DATA_W + WGT_W;
  localparam int SW = PW + 4;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  logic signed [PW-1:0]    prodN [NUM_CH][4][9];
  logic signed [PW-1:0]    prod1 [NUM_CH][4][9];
  logic signed [SW-1:0]    chN [NUM_CH][4];
  logic signed [SW-1:0]    ch2 [NUM_CH][4];
  logic signed [ACC_W-1:0] posN [4];
  logic signed [ACC_W-1:0] pos3 [4];
  logic signed [ACC_W-1:0] accN [4];
  logic signed [ACC_W-1:0] acc [4];
  logic [ACC_W-1:0]        dN [4];
  logic [2:0]              vldP, fstP, lstP;
  logic signed [BIAS_W-1:0] bias1, bias2, bias3;
  logic signed [ACC_W-1:0] biasExt;
  logic [0:0]              state;
  logic                    fin;
  logic [4*OUT_W-1:0]      posFlat;
  logic [OUT_W-1:0]        pxN;

  function automatic logic [ACC_W-1:0] satAdd(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    return (s[ACC_W] != s[ACC_W-1]) ? (s[ACC_W] ? ACC_MIN : ACC_MAX) : s[ACC_W-1:0];
  endfunction

  // window p sits at (p>>1, p&1); tap t reads patch pixel (row+t/3, col+t%3)
  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      for (int p = 0; p < 4; p++)
        for (int t = 0; t < 9; t++)
          prodN[c][p][t] = $signed(PW'(i_din[(c*16 + ((p>>1) + t/3)*4 + (p&1) + t%3)*DATA_W +: DATA_W]))
                         * $signed(PW'($signed(i_wgt[(c*9 + t)*WGT_W +: WGT_W])));
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      for (int p = 0; p < 4; p++) begin
        chN[c][p] = '0;
        for (int t = 0; t < 9; t++)
          chN[c][p] = chN[c][p] + SW'(prod1[c][p][t]);
      end
  end

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      posN[p] = '0;
      for (int c = 0; c < NUM_CH; c++)
        posN[p] = posN[p] + ACC_W'(ch2[c][p]);
    end
  end

  always_comb begin
    biasExt = ACC_W'(bias3) <<< BIAS_SHIFT;
    posFlat = '0;
    pxN = '0;
    for (int p = 0; p < 4; p++) begin
      accN[p] = satAdd(pos3[p], fstP[2] ? biasExt : acc[p]);
      dN[p] = acc[p][ACC_W-1] ? '0 : acc[p] >>> SHIFT;
      dN[p] = dN[p] > OUT_MAX ? OUT_MAX : dN[p];
      posFlat[p*OUT_W +: OUT_W] = dN[p][OUT_W-1:0];
      pxN = dN[p][OUT_W-1:0] > pxN ? dN[p][OUT_W-1:0] : pxN;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vldP <= '0;
      fstP <= '0;
      lstP <= '0;
      bias1 <= '0;
      bias2 <= '0;
      bias3 <= '0;
      for (int c = 0; c < NUM_CH; c++)
        for (int p = 0; p < 4; p++) begin
          ch2[c][p] <= '0;
          for (int t = 0; t < 9; t++)
            prod1[c][p][t] <= '0;
        end
      for (int p = 0; p < 4; p++)
        pos3[p] <= '0;
    end else begin
      vldP <= {vldP[1:0], i_vld};
      fstP <= {fstP[1:0], i_first};
      lstP <= {lstP[1:0], i_last};
      bias1 <= i_bias;
      bias2 <= bias1;
      bias3 <= bias2;
      prod1 <= prodN;
      ch2 <= chN;
      pos3 <= posN;
    end
  end

  // a first beat always (re)loads; mid/last beats only count inside a frame
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      fin <= 1'b0;
      o_err <= 1'b0;
      for (int p = 0; p < 4; p++)
        acc[p] <= '0;
    end else begin
      fin <= 1'b0;
      if (vldP[2] && (fstP[2] || state == ACCUM)) begin
        acc <= accN;
        state <= lstP[2] ? IDLE : ACCUM;
        fin <= lstP[2];
      end
      if (vldP[2] && (fstP[2] == (state == ACCUM)))
        o_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_vld <= 1'b0;
      o_px <= '0;
      o_pos <= '0;
    end else begin
      o_vld <= fin;
      if (fin) begin
        o_px <= pxN;
        o_pos <= posFlat;
      end
    end
  end

  assign o_busy = state == ACCUM;
endmodule

// File: tb/tb_conv_mac_pool_bank.sv
// tb_conv_mac_pool_bank: directed and randomized frames checked cycle by cycle against a beat-level arithmetic model
module tb_conv_mac_pool_bank;
  localparam int NC = 8;
  localparam longint AMAX = 2147483647;
  localparam longint AMIN = -AMAX - 1;

  logic clk = 0, rstn = 1, i_vld = 0, i_first = 0, i_last = 0;
  logic [NC*16*8-1:0] i_din = '0;
  logic [NC*9*8-1:0] i_wgt = '0;
  logic [15:0] i_bias = '0;
  logic o_vld, o_busy, o_err;
  logic [7:0] o_px;
  logic [31:0] o_pos;

  int checks = 0, failures = 0, cnt = 0;
  int pix [NC][16];
  int wt [NC][9];
  longint macc [4];
  bit mActive = 0, mErr = 0;

  typedef struct {int due; bit busy; bit err;} st_t;
  typedef struct {int due; logic [7:0] px; logic [31:0] pos;} out_t;
  st_t stQ[$];
  out_t outQ[$];
  bit curBusy = 0, curErr = 0;
  logic [7:0] curPx = 0;
  logic [31:0] curPos = 0;

  conv_mac_pool_bank #(.NUM_CH(NC), .SHIFT(0)) dut (
    .clk(clk), .rstn(rstn), .i_vld(i_vld), .i_first(i_first), .i_last(i_last),
    .i_din(i_din), .i_wgt(i_wgt), .i_bias(i_bias),
    .o_vld(o_vld), .o_px(o_px), .o_pos(o_pos), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cnt, got, exp);
    end
  endtask

  always @(negedge clk) begin
    st_t s;
    out_t o;
    bit ve;
    while (stQ.size() > 0 && stQ[0].due <= cnt) begin
      s = stQ.pop_front();
      curBusy = s.busy;
      curErr = s.err;
    end
    ve = 0;
    if (outQ.size() > 0 && outQ[0].due <= cnt) begin
      o = outQ.pop_front();
      curPx = o.px;
      curPos = o.pos;
      ve = 1;
    end
    chk("o_vld", 64'(o_vld), 64'(ve));
    chk("o_px", 64'(o_px), 64'(curPx));
    chk("o_pos", 64'(o_pos), 64'(curPos));
    chk("o_busy", 64'(o_busy), 64'(curBusy));
    chk("o_err", 64'(o_err), 64'(curErr));
  end

  function automatic longint conv(input int p);
    longint s = 0;
    for (int c = 0; c < NC; c++)
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++)
          s += longint'(pix[c][((p >> 1) + ky)*4 + (p & 1) + kx]) * longint'(wt[c][ky*3 + kx]);
    return s;
  endfunction

  function automatic longint clamp(input longint v);
    return v > AMAX ? AMAX : (v < AMIN ? AMIN : v);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    rstn = 0;
    i_vld = 0;
    stQ.delete();
    outQ.delete();
    curBusy = 0;
    curErr = 0;
    curPx = 0;
    curPos = 0;
    mActive = 0;
    mErr = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1;
  endtask

  task automatic setAll(input int d, input int w);
    for (int c = 0; c < NC; c++) begin
      for (int k = 0; k < 16; k++) pix[c][k] = d;
      for (int t = 0; t < 9; t++) wt[c][t] = w;
    end
  endtask

  task automatic fillRand(input int dmax, input int wmax);
    for (int c = 0; c < NC; c++) begin
      for (int k = 0; k < 16; k++) pix[c][k] = int'($urandom_range(0, dmax));
      for (int t = 0; t < 9; t++) wt[c][t] = int'($urandom_range(0, 2*wmax)) - wmax;
    end
  endtask

  task automatic beat(input bit f, input bit l, input int bias);
    longint cv [4];
    longint v;
    bit fin = 0;
    logic [7:0] px = 0;
    logic [31:0] pos = 0;
    st_t s;
    out_t o;
    for (int c = 0; c < NC; c++) begin
      for (int k = 0; k < 16; k++) i_din[(c*16 + k)*8 +: 8] = 8'(pix[c][k]);
      for (int t = 0; t < 9; t++) i_wgt[(c*9 + t)*8 +: 8] = 8'(wt[c][t]);
    end
    i_vld = 1;
    i_first = f;
    i_last = l;
    i_bias = 16'(bias);
    for (int p = 0; p < 4; p++) cv[p] = conv(p);
    if (f) begin
      mErr |= mActive;
      for (int p = 0; p < 4; p++) macc[p] = clamp(cv[p] + longint'(bias));
      mActive = !l;
      fin = l;
    end else if (mActive) begin
      for (int p = 0; p < 4; p++) macc[p] = clamp(macc[p] + cv[p]);
      mActive = !l;
      fin = l;
    end else
      mErr = 1;
    s.due = cnt + 4;
    s.busy = mActive;
    s.err = mErr;
    stQ.push_back(s);
    if (fin) begin
      for (int p = 0; p < 4; p++) begin
        v = macc[p] < 0 ? 0 : macc[p];
        if (v > 255) v = 255;
        pos[p*8 +: 8] = 8'(v);
        if (8'(v) > px) px = 8'(v);
      end
      o.due = cnt + 5;
      o.px = px;
      o.pos = pos;
      outQ.push_back(o);
    end
    @(posedge clk);
    #1;
    i_vld = 0;
    i_first = 0;
    i_last = 0;
  endtask

  initial begin
    int n, dm, wm;
    bit f, l;
    #2;
    doReset();
    idle(3);
    setAll(1, 1);    beat(1, 1, 0); idle(6);
    setAll(1, -1);   beat(1, 1, 0); idle(6);
    setAll(255, 127); beat(1, 1, 0); idle(6);
    setAll(1, 1);
    beat(1, 0, 16); beat(0, 0, -99); beat(0, 1, 77); idle(6);
    setAll(0, 0);
    wt[0][4] = 1;
    pix[0][5] = 10; pix[0][6] = 40; pix[0][9] = 20; pix[0][10] = 30;
    beat(1, 1, 0); idle(6);
    setAll(1, 1);    beat(0, 1, 0); idle(6);
    beat(1, 0, 0);
    setAll(2, 1);    beat(1, 1, 5); idle(6);
    setAll(1, 1);    beat(1, 0, 0); idle(1);
    doReset();
    beat(1, 1, 3); idle(6);
    for (int fr = 0; fr < 60; fr++) begin
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 2))
          0: dm = 3;
          1: dm = 15;
          default: dm = 255;
        endcase
        case ($urandom_range(0, 2))
          0: wm = 2;
          1: wm = 8;
          default: wm = 127;
        endcase
        fillRand(dm, wm);
        f = (i == 0);
        l = (i == n - 1);
        if ($urandom_range(0, 11) == 0) f = !f;
        if ($urandom_range(0, 11) == 0) l = !l;
        beat(f, l, int'($urandom_range(0, 600)) - 300);
        idle(int'($urandom_range(0, 2)));
      end
    end
    idle(6);
    setAll(255, 127);
    beat(1, 0, 0);
    repeat (998) beat(0, 0, 0);
    beat(0, 1, 0);
    idle(8);
    chk("drain", 64'(outQ.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
